// File: rtl/execute_issue_controller_if.sv
// rtl/execute_issue_controller_if.sv - decode/execute/writeback bundle for the issue controller
interface execute_issue_controller_if #(
    parameter int REGISTER_WIDTH = 32,
    parameter int REG_ADDR_W     = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [REG_ADDR_W-1:0]     in_rd;
    logic [REG_ADDR_W-1:0]     in_rs1;
    logic [REG_ADDR_W-1:0]     in_rs2;
    logic                      in_uses_rs1;
    logic                      in_uses_rs2;
    logic                      in_writes_rd;
    logic                      issue_valid;
    logic [REGISTER_WIDTH-1:0] alu_result;
    logic                      wb_valid;
    logic [REG_ADDR_W-1:0]     wb_rd;
    logic [REGISTER_WIDTH-1:0] wb_data;
    logic                      busy;
    logic [31:0]               stall_count;

    modport master (
        output in_valid, in_rd, in_rs1, in_rs2, in_uses_rs1, in_uses_rs2, in_writes_rd, alu_result,
        input  in_ready, issue_valid, wb_valid, wb_rd, wb_data, busy, stall_count
    );

    modport slave (
        input  in_valid, in_rd, in_rs1, in_rs2, in_uses_rs1, in_uses_rs2, in_writes_rd, alu_result,
        output in_ready, issue_valid, wb_valid, wb_rd, wb_data, busy, stall_count
    );
endinterface

// File: rtl/execute_issue_controller.sv
// rtl/execute_issue_controller.sv - scoreboarded in-order issue with fixed-latency retire to writeback
module execute_issue_controller #(
    parameter int REGISTER_WIDTH = 32,
    parameter int NUM_REGS       = 32,
    parameter int REG_ADDR_W     = $clog2(NUM_REGS),
    parameter int EXEC_LATENCY   = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    execute_issue_controller_if.slave   bus
);
    localparam int L = EXEC_LATENCY;

    logic [NUM_REGS-1:0]       sb_q, sb_d;
    logic [L-1:0]              pipe_valid_q, pipe_valid_d;
    logic [L-1:0]              pipe_wr_q, pipe_wr_d;
    logic [REG_ADDR_W-1:0]     pipe_rd_q [L];
    logic [REG_ADDR_W-1:0]     pipe_rd_d [L];
    logic [REGISTER_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [31:0]               stall_count_q, stall_count_d;

    logic hazard;
    logic issue;
    logic set_en;
    logic retire_en;
    logic [REG_ADDR_W-1:0] retire_rd;

    // Destination check also blocks WAW so a retire never races a new set of the same bit.
    assign hazard = (bus.in_uses_rs1  && sb_q[bus.in_rs1]) ||
                    (bus.in_uses_rs2  && sb_q[bus.in_rs2]) ||
                    (bus.in_writes_rd && sb_q[bus.in_rd]);

    assign bus.in_ready    = !hazard && !flush;
    assign issue           = bus.in_valid && bus.in_ready;
    assign bus.issue_valid = issue;
    assign set_en          = issue && bus.in_writes_rd && (bus.in_rd != '0);

    assign retire_en       = pipe_valid_q[L-1] && pipe_wr_q[L-1];
    assign retire_rd       = pipe_rd_q[L-1];

    assign bus.wb_valid    = retire_en;
    assign bus.wb_rd       = retire_rd;
    assign bus.wb_data     = wb_data_q;
    assign bus.busy        = |pipe_valid_q;
    assign bus.stall_count = stall_count_q;

    always_comb begin
        sb_d          = sb_q;
        pipe_valid_d  = pipe_valid_q;
        pipe_wr_d     = pipe_wr_q;
        pipe_rd_d     = pipe_rd_q;
        wb_data_d     = wb_data_q;
        stall_count_d = stall_count_q;

        pipe_valid_d[0] = issue;
        pipe_wr_d[0]    = bus.in_writes_rd && (bus.in_rd != '0);
        pipe_rd_d[0]    = bus.in_rd;
        for (int k = 1; k < L; k++) begin
            pipe_valid_d[k] = pipe_valid_q[k-1];
            pipe_wr_d[k]    = pipe_wr_q[k-1];
            pipe_rd_d[k]    = pipe_rd_q[k-1];
        end

        // Whatever enters the last stage this edge is the op whose result is on alu_result now.
        if (pipe_valid_d[L-1] && pipe_wr_d[L-1]) begin
            wb_data_d = bus.alu_result;
        end

        if (retire_en) begin
            sb_d[retire_rd] = 1'b0;
        end
        if (set_en) begin
            sb_d[bus.in_rd] = 1'b1;
        end

        if (flush) begin
            sb_d         = '0;
            pipe_valid_d = '0;
        end
        sb_d[0] = 1'b0;

        if (bus.in_valid && !bus.in_ready && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_q          <= '0;
            pipe_valid_q  <= '0;
            pipe_wr_q     <= '0;
            wb_data_q     <= '0;
            stall_count_q <= '0;
            for (int k = 0; k < L; k++) begin
                pipe_rd_q[k] <= '0;
            end
        end else begin
            sb_q          <= sb_d;
            pipe_valid_q  <= pipe_valid_d;
            pipe_wr_q     <= pipe_wr_d;
            pipe_rd_q     <= pipe_rd_d;
            wb_data_q     <= wb_data_d;
            stall_count_q <= stall_count_d;
        end
    end

    set_retire_collision_a: assert property (@(posedge clk) disable iff (!reset_n)
        !(set_en && retire_en && (bus.in_rd == retire_rd)));

endmodule

// File: tb/tb_execute_issue_controller.sv
// tb/tb_execute_issue_controller.sv - randomized scoreboard bench for execute_issue_controller
module tb_execute_issue_controller;
    localparam int W   = 32;
    localparam int AW  = 5;
    localparam int LAT = 3;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic flush   = 1'b0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    execute_issue_controller_if #(.REGISTER_WIDTH(W), .REG_ADDR_W(AW)) bus();

    execute_issue_controller #(
        .REGISTER_WIDTH(W), .NUM_REGS(32), .REG_ADDR_W(AW), .EXEC_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus.slave)
    );

    wb_t         exp_q[$];
    int          inflight[$];
    int          free_at[32];
    logic [31:0] alu_sched[int];
    logic [31:0] stall_exp;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) free_at[i] = 0;
        exp_q.delete();
        inflight.delete();
        alu_sched.delete();
        stall_exp = 32'd0;
    endtask

    task automatic idle_inputs();
        bus.in_valid     = 1'b0;
        bus.in_rd        = '0;
        bus.in_rs1       = '0;
        bus.in_rs2       = '0;
        bus.in_uses_rs1  = 1'b0;
        bus.in_uses_rs2  = 1'b0;
        bus.in_writes_rd = 1'b0;
        bus.alu_result   = '0;
        flush            = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    // One cycle starting at a falling edge: drive, compare against the model, advance the model.
    task automatic step(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic wr, input logic fl);
        logic        hz, exp_ready, exp_busy;
        logic [31:0] data;
        bus.in_valid     = v;
        bus.in_rd        = rd;
        bus.in_rs1       = rs1;
        bus.in_rs2       = rs2;
        bus.in_uses_rs1  = u1;
        bus.in_uses_rs2  = u2;
        bus.in_writes_rd = wr;
        flush            = fl;
        bus.alu_result   = alu_sched.exists(cyc) ? alu_sched[cyc] : $urandom;
        #1;
        hz = (u1 && cyc < free_at[rs1]) || (u2 && cyc < free_at[rs2]) || (wr && cyc < free_at[rd]);
        exp_ready = !hz && !fl;
        while (inflight.size() > 0 && inflight[0] < cyc - LAT) void'(inflight.pop_front());
        exp_busy = (inflight.size() > 0);
        check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
        check("issue_valid", 64'(bus.issue_valid), 64'(v && exp_ready));
        check("busy", 64'(bus.busy), 64'(exp_busy));
        check("stall_count", 64'(bus.stall_count), 64'(stall_exp));
        if (v && exp_ready) begin
            inflight.push_back(cyc);
            if (wr && rd != 5'd0) begin
                data = $urandom;
                free_at[rd] = cyc + LAT + 1;
                exp_q.push_back('{due: cyc + LAT, rd: rd, data: data});
                if (LAT == 1) bus.alu_result = data;
                else alu_sched[cyc + LAT - 1] = data;
            end
        end
        if (v && !exp_ready && stall_exp != 32'hFFFF_FFFF) stall_exp++;
        if (fl) begin
            for (int i = 0; i < 32; i++) if (free_at[i] > cyc + 1) free_at[i] = cyc + 1;
            inflight.delete();
            for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].due > cyc) exp_q.delete(i);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Writeback monitor: every wb pulse must match the oldest expected retire, in the expected cycle.
    always @(negedge clk) begin
        #2;
        if (reset_n) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL wb_missing: rd %0d due cycle %0d, no writeback observed", exp_q[0].rd, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (bus.wb_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wb_unexpected: rd %0d data %0h at cycle %0d, none expected",
                             bus.wb_rd, bus.wb_data, cyc);
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    check("wb_cycle", 64'(cyc), 64'(e.due));
                    check("wb_rd", 64'(bus.wb_rd), 64'(e.rd));
                    check("wb_data", 64'(bus.wb_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        idle_inputs();
        model_reset();
        @(negedge clk);
        do_reset();
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_stall", 64'(bus.stall_count), 64'd0);
        @(negedge clk);

        step(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(LAT + 1);

        step(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(LAT + 1);

        step(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i <= LAT; i++) step(1'b1, 5'd2, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(LAT + 1);

        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(LAT + 1);

        step(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(LAT + 2);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 3));
        end
        idle(LAT + 2);

        do_reset();
        @(negedge clk);
        step(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_inputs();
        #3;
        reset_n = 1'b0;
        #1;
        check("midreset_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("midreset_busy", 64'(bus.busy), 64'd0);
        check("midreset_wb_rd", 64'(bus.wb_rd), 64'd0);
        check("midreset_stall", 64'(bus.stall_count), 64'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(LAT + 3);

        flush        = 1'b1;
        bus.in_valid = 1'b1;
        force dut.stall_count_d = 32'hFFFF_FFFD;
        @(negedge clk);
        release dut.stall_count_d;
        #1 bus.in_valid = 1'b0;
        #1 bus.in_valid = 1'b1;
        #1;
        check("sat_preset", 64'(bus.stall_count), 64'hFFFF_FFFD);
        @(negedge clk);
        #1 check("sat_fffe", 64'(bus.stall_count), 64'hFFFF_FFFE);
        @(negedge clk);
        #1 check("sat_ffff", 64'(bus.stall_count), 64'hFFFF_FFFF);
        @(negedge clk);
        #1 check("sat_hold", 64'(bus.stall_count), 64'hFFFF_FFFF);
        @(negedge clk);
        #1 check("sat_hold2", 64'(bus.stall_count), 64'hFFFF_FFFF);
        idle_inputs();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
        $fatal(1);
    end
endmodule
